// File: rtl/cmos_pkg.sv
// Shared camera/display definitions: input format encodings and RGB565 expansion.
package cmos_pkg;

  typedef enum logic [1:0] {
    FMT_RGB565 = 2'd0,
    FMT_RAW8   = 2'd1,
    FMT_YUYV   = 2'd2,
    FMT_RSVD   = 2'd3
  } fmt_e;

  // Zero-fill the low bits of each channel when widening 5/6/5 to 8/8/8.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/cmos_byte_pack.sv
// Byte phase tracking and pixel assembly from the registered camera byte stream.
module cmos_byte_pack
  import cmos_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        href,
  input  logic [7:0]  data,
  input  fmt_e        fmt,
  output logic        pixel_done,
  output logic [23:0] pixel_data
);

  logic       phase_q;
  logic [7:0] first_q;

  // Phase toggles per byte inside a line; the first byte of a pair is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      first_q <= 8'h00;
    end else if (!href) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      if (!phase_q) first_q <= data;
    end
  end

  // Format decode; the reserved code behaves as RGB565.
  always_comb begin
    pixel_done = 1'b0;
    pixel_data = 24'h000000;
    case (fmt)
      FMT_RAW8: begin
        pixel_done = href;
        pixel_data = {data, data, data};
      end
      FMT_YUYV: begin
        pixel_done = href & phase_q;
        pixel_data = {first_q, first_q, first_q};
      end
      default: begin
        pixel_done = href & phase_q;
        pixel_data = rgb565_to_888({first_q, data});
      end
    endcase
  end

endmodule

// File: rtl/cmos_capture_win.sv
// OV5640 capture: settling, pixel assembly, windowed crop with x/y tags, frame/line status.
module cmos_capture_win
  import cmos_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned WAIT_FRAME = 10,
  parameter int unsigned XW         = 12,
  parameter int unsigned YW         = 11
) (
  input  logic          cam_pclk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [DW-1:0] cam_data,
  input  logic [1:0]    fmt_sel,
  input  logic          cfg_update,
  input  logic [XW-1:0] win_x0,
  input  logic [XW-1:0] win_x1,
  input  logic [YW-1:0] win_y0,
  input  logic [YW-1:0] win_y1,
  output logic          frame_vsync,
  output logic          frame_href,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          line_err
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_FRAME);

  logic          vsync_d0, vsync_d1, href_d0, href_d1;
  logic [7:0]    data_d0;
  logic          vs_rise, hr_fall;
  logic [3:0]    settle_cnt;
  logic          frame_active;
  logic [XW-1:0] sx0, sx1;
  logic [YW-1:0] sy0, sy1;
  fmt_e          sfmt;
  logic [XW-1:0] x_cnt, prev_len;
  logic [YW-1:0] y_cnt;
  logic [XW:0]   byte_cnt;
  logic          pixel_done;
  logic [23:0]   pk_data;
  logic          in_win, emit, len_bad, odd_bad;

  assign vs_rise     = vsync_d0 & ~vsync_d1;
  assign hr_fall     = ~href_d0 & href_d1;
  assign frame_vsync = vsync_d1 & frame_active;
  assign frame_href  = href_d1 & frame_active;

  // Two-stage input pipeline; only the top 8 data bits are kept.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      vsync_d0 <= 1'b0;
      vsync_d1 <= 1'b0;
      href_d0  <= 1'b0;
      href_d1  <= 1'b0;
      data_d0  <= 8'h00;
    end else begin
      vsync_d0 <= cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= cam_href;
      href_d1  <= href_d0;
      data_d0  <= cam_data[DW-1 -: 8];
    end
  end

  cmos_byte_pack u_pack (
    .clk        (cam_pclk),
    .rst        (rst),
    .href       (href_d0),
    .data       (data_d0),
    .fmt        (sfmt),
    .pixel_done (pixel_done),
    .pixel_data (pk_data)
  );

  // Settling counter; cfg_update wins over a coincident frame start.
  always_ff @(posedge cam_pclk) begin
    if (rst || cfg_update) begin
      settle_cnt   <= 4'd0;
      frame_active <= 1'b0;
    end else if (vs_rise) begin
      if (settle_cnt < WaitCnt) settle_cnt <= settle_cnt + 4'd1;
      else                      frame_active <= 1'b1;
    end
  end

  // Window/format shadows so mid-frame changes apply from the next frame.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      sx0  <= '0;
      sx1  <= '0;
      sy0  <= '0;
      sy1  <= '0;
      sfmt <= FMT_RGB565;
    end else if (cfg_update || vs_rise) begin
      sx0  <= win_x0;
      sx1  <= win_x1;
      sy0  <= win_y0;
      sy1  <= win_y1;
      sfmt <= fmt_e'(fmt_sel);
    end
  end

  // Saturating pixel/line/byte counters and the previous line length.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      byte_cnt <= '0;
      prev_len <= '0;
    end else begin
      if (hr_fall)                        x_cnt <= '0;
      else if (pixel_done && x_cnt != '1) x_cnt <= x_cnt + 1'b1;
      if (vs_rise)                        y_cnt <= '0;
      else if (hr_fall && y_cnt != '1)    y_cnt <= y_cnt + 1'b1;
      if (hr_fall)                        byte_cnt <= '0;
      else if (href_d0 && byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
      if (hr_fall)                        prev_len <= x_cnt;
    end
  end

  assign in_win  = (x_cnt >= sx0) && (x_cnt <= sx1) && (y_cnt >= sy0) && (y_cnt <= sy1);
  assign emit    = frame_active & pixel_done & in_win;
  // First line of a frame has no reference length.
  assign len_bad = (y_cnt != '0) && (x_cnt != prev_len);
  assign odd_bad = (sfmt != FMT_RAW8) && byte_cnt[0];

  // Registered pixel strobe, tagged coordinates and frame/line status.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_data   <= 24'h000000;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
      line_err   <= 1'b0;
    end else begin
      pix_valid  <= emit;
      if (emit) begin
        pix_data <= pk_data;
        pix_x    <= x_cnt;
        pix_y    <= y_cnt;
      end
      frame_done <= vs_rise & frame_active & (y_cnt != '0);
      if (vs_rise && frame_active && (y_cnt != '0)) frame_cnt <= frame_cnt + 16'd1;
      if (cfg_update)                          line_err <= 1'b0;
      else if (hr_fall && (len_bad || odd_bad)) line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_capture_win.sv
// Scoreboard bench for cmos_capture_win: stimulus pushes expected pixels, monitor pops.
module tb_cmos_capture_win;
  import cmos_pkg::*;

  localparam int unsigned WAIT = 2;
  localparam int unsigned XW   = 12;
  localparam int unsigned YW   = 11;

  logic          clk = 1'b0;
  logic          rst, cam_vsync, cam_href, cfg_update;
  logic [7:0]    cam_data;
  logic [1:0]    fmt_sel;
  logic [XW-1:0] win_x0, win_x1;
  logic [YW-1:0] win_y0, win_y1;
  logic          frame_vsync, frame_href, pix_valid, frame_done, line_err;
  logic [23:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   frame_cnt;

  cmos_capture_win #(
    .DW         (8),
    .WAIT_FRAME (WAIT),
    .XW         (XW),
    .YW         (YW)
  ) dut (
    .cam_pclk    (clk),
    .rst         (rst),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .fmt_sel     (fmt_sel),
    .cfg_update  (cfg_update),
    .win_x0      (win_x0),
    .win_x1      (win_x1),
    .win_y0      (win_y0),
    .win_y1      (win_y1),
    .frame_vsync (frame_vsync),
    .frame_href  (frame_href),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .line_err    (line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [23:0] d;
    int          x;
    int          y;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0, n_pix = 0, n_done = 0;

  // Reference state: settling progress and per-frame shadows.
  int         m_settle = 0;
  bit         m_active = 1'b0;
  int         ex0, ex1, ey0, ey1;
  logic [1:0] m_fmt;

  // Monitor: every pixel strobe pops one expectation (data, coords, arrival cycle).
  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (pix_valid) begin
      exp_t e;
      n_pix++;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL pix_unexpected: got data=%h x=%0d y=%0d cyc=%0d, required no pixel",
                 pix_data, pix_x, pix_y, cyc);
      end else begin
        e = q.pop_front();
        if (pix_data !== e.d || int'(pix_x) != e.x || int'(pix_y) != e.y || cyc != e.c) begin
          n_err++;
          $display("FAIL pix: got data=%h x=%0d y=%0d cyc=%0d, required data=%h x=%0d y=%0d cyc=%0d",
                   pix_data, pix_x, pix_y, cyc, e.d, e.x, e.y, e.c);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [23:0] ref565(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:3], 3'b000, hi[2:0], lo[7:5], 2'b00, lo[4:0], 3'b000};
  endfunction

  function automatic logic [7:0] get_byte(input int mode, input int l, input int i);
    case (mode)
      0: return (i % 2 == 1) ? 8'h1F : 8'hF8;
      1: return 8'(i + 4 * l);
      2: begin
        case (i % 4)
          0:       return 8'h80;
          1:       return 8'h10;
          2:       return 8'h40;
          default: return 8'h20;
        endcase
      end
      default: return 8'(3 * i + l + 1);
    endcase
  endfunction

  task automatic set_full_win();
    win_x0 = '0;
    win_x1 = '1;
    win_y0 = '0;
    win_y1 = '1;
  endtask

  // One frame: vsync pulse, then nlines lines; optionally rewrites win_x1 mid-line.
  task automatic send_frame(input int nlines, input int len0, input int len_last,
                            input int mode, input int chg_line, input int chg_val);
    int          len, x;
    logic [7:0]  b, prev_b;
    logic [23:0] p;
    bit          done;
    exp_t        e;
    @(posedge clk); #1 cam_vsync = 1'b1;
    m_fmt = fmt_sel;
    ex0 = int'(win_x0); ex1 = int'(win_x1); ey0 = int'(win_y0); ey1 = int'(win_y1);
    if (m_settle == int'(WAIT)) m_active = 1'b1;
    else                        m_settle++;
    repeat (2) @(posedge clk);
    #1 cam_vsync = 1'b0;
    repeat (3) @(posedge clk);
    for (int l = 0; l < nlines; l++) begin
      len = (l == nlines - 1) ? len_last : len0;
      prev_b = 8'h00;
      for (int i = 0; i < len; i++) begin
        @(posedge clk); #1;
        cam_href = 1'b1;
        b = get_byte(mode, l, i);
        cam_data = b;
        if (l == chg_line && i == 1) win_x1 = XW'(chg_val);
        done = 1'b0;
        x = 0;
        p = 24'h0;
        if (m_fmt == 2'd1) begin
          done = 1'b1; x = i; p = {b, b, b};
        end else if (i % 2 == 1) begin
          done = 1'b1; x = i / 2;
          p = (m_fmt == 2'd2) ? {prev_b, prev_b, prev_b} : ref565(prev_b, b);
        end
        if (done && m_active && x >= ex0 && x <= ex1 && l >= ey0 && l <= ey1) begin
          e.d = p; e.x = x; e.y = l; e.c = cyc + 2;
          q.push_back(e);
        end
        prev_b = b;
      end
      @(posedge clk); #1 cam_href = 1'b0; cam_data = 8'h00;
      repeat (3) @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_cfg();
    @(posedge clk); #1 cfg_update = 1'b1;
    m_settle = 0; m_active = 1'b0;
    @(posedge clk); #1 cfg_update = 1'b0;
  endtask

  int p0;
  int settle_exp[4] = '{0, 0, 8, 8};

  initial begin
    rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    cfg_update = 1'b0; fmt_sel = 2'd0;
    set_full_win();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pix_data", {8'd0, pix_data}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_line_err", {31'd0, line_err}, 32'd0);
    chk("rst_frame_vsync", {31'd0, frame_vsync}, 32'd0);
    #1 rst = 1'b0;

    // Settling with RGB565 4x2 frames.
    for (int f = 0; f < 4; f++) begin
      p0 = n_pix;
      send_frame(2, 8, 8, 0, -1, 0);
      chk($sformatf("settle_f%0d_pixels", f + 1), n_pix - p0, settle_exp[f]);
      if (f == 2) chk("rgb565_F81F", {8'd0, pix_data}, 32'h00F800F8);
    end
    chk("settle_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("settle_done_pulses", n_done, 32'd1);

    // Crop x 1..2, y 1..1 on RAW8 4x3.
    fmt_sel = 2'd1;
    win_x0 = 12'd1; win_x1 = 12'd2; win_y0 = 11'd1; win_y1 = 11'd1;
    p0 = n_pix;
    send_frame(3, 4, 4, 1, -1, 0);
    chk("crop_pixels", n_pix - p0, 32'd2);
    chk("crop_last_data", {8'd0, pix_data}, 32'h00060606);
    chk("crop_last_x", {20'd0, pix_x}, 32'd2);
    chk("crop_last_y", {21'd0, pix_y}, 32'd1);
    chk("crop_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // YUYV single line.
    fmt_sel = 2'd2;
    set_full_win();
    p0 = n_pix;
    send_frame(1, 4, 4, 2, -1, 0);
    chk("yuyv_pixels", n_pix - p0, 32'd2);
    chk("yuyv_last_data", {8'd0, pix_data}, 32'h00404040);
    chk("yuyv_last_x", {20'd0, pix_x}, 32'd1);

    // win_x1 rewritten during row 1 applies only to the following frame.
    fmt_sel = 2'd1;
    win_x1 = 12'd3;
    p0 = n_pix;
    send_frame(3, 4, 4, 3, 1, 1);
    chk("midchg_same_frame", n_pix - p0, 32'd12);
    p0 = n_pix;
    send_frame(3, 4, 4, 3, -1, 0);
    chk("midchg_next_frame", n_pix - p0, 32'd6);

    // Line length error 8,8,6 is sticky until cfg_update.
    set_full_win();
    chk("lerr_before", {31'd0, line_err}, 32'd0);
    p0 = n_pix;
    send_frame(3, 8, 6, 3, -1, 0);
    chk("lerr_frame_pixels", n_pix - p0, 32'd22);
    chk("lerr_set", {31'd0, line_err}, 32'd1);
    p0 = n_pix;
    send_frame(2, 8, 8, 3, -1, 0);
    chk("lerr_next_pixels", n_pix - p0, 32'd16);
    chk("lerr_sticky", {31'd0, line_err}, 32'd1);
    chk("lerr_frame_cnt", {16'd0, frame_cnt}, 32'd7);
    pulse_cfg();
    @(negedge clk);
    chk("lerr_cfg_clear", {31'd0, line_err}, 32'd0);
    p0 = n_pix;
    send_frame(2, 8, 8, 3, -1, 0);
    chk("cfg_resettle_pixels", n_pix - p0, 32'd0);
    chk("cfg_frame_cnt", {16'd0, frame_cnt}, 32'd7);

    // One-cycle reset in the middle of a 5-byte line.
    @(posedge clk); #1 cam_href = 1'b1; cam_data = 8'h11;
    @(posedge clk); #1 cam_data = 8'h22;
    @(posedge clk); #1 cam_data = 8'h33; rst = 1'b1;
    @(posedge clk); #1 cam_data = 8'h44; rst = 1'b0;
    m_settle = 0; m_active = 1'b0;
    @(negedge clk);
    chk("mrst_pix_data", {8'd0, pix_data}, 32'd0);
    chk("mrst_pix_x", {20'd0, pix_x}, 32'd0);
    chk("mrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("mrst_frame_href", {31'd0, frame_href}, 32'd0);
    @(posedge clk); #1 cam_data = 8'h55;
    @(posedge clk); #1 cam_href = 1'b0; cam_data = 8'h00;
    repeat (4) @(posedge clk);
    for (int f = 0; f < 3; f++) begin
      p0 = n_pix;
      send_frame(1, 4, 4, 3, -1, 0);
      chk($sformatf("mrst_f%0d_pixels", f + 1), n_pix - p0, (f == 2) ? 32'd4 : 32'd0);
    end
    chk("mrst_line_err", {31'd0, line_err}, 32'd0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
